// File: rtl/lsqueue_pkg.sv
// Shared types and defaults for the load/store queue and its entry slots.
package lsqueue_pkg;

  localparam int LSQ_TAG_W  = 6;
  localparam int LSQ_DATA_W = 32;
  localparam int LSQ_IMM_W  = 16;

  // One queue slot. Storage widths follow the package defaults; the top
  // level defaults its TAG_W/DATA_W to the same values, so widening the
  // queue means widening these localparams.
  typedef struct packed {
    logic                  valid;
    logic                  store;
    logic [LSQ_IMM_W-1:0]  imm;
    logic [LSQ_DATA_W-1:0] rsData;
    logic [LSQ_DATA_W-1:0] rtData;
    logic [LSQ_TAG_W-1:0]  rsTag;
    logic [LSQ_TAG_W-1:0]  rtTag;
    logic                  rsValid;
    logic                  rtValid;
    logic [LSQ_TAG_W-1:0]  rdTag;
  } lsq_entry_t;

  // True when a still-pending operand is satisfied by the current broadcast.
  function automatic logic cdbHit(input logic                 opValid,
                                  input logic [LSQ_TAG_W-1:0] opTag,
                                  input logic                 cdbValid,
                                  input logic [LSQ_TAG_W-1:0] cdbTag);
    return !opValid && cdbValid && (opTag == cdbTag);
  endfunction

endpackage

// File: rtl/lsqueue_entry.sv
// A single load/store queue slot: holds one memory op, snoops the CDB for
// missing operands, and presents its issue readiness and computed address.
module lsq_entry
  import lsqueue_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  write_i,
  input  lsq_entry_t            wrEntry_i,
  input  logic                  pop_i,
  input  logic                  cdbValid_i,
  input  logic [LSQ_TAG_W-1:0]  cdbTag_i,
  input  logic [LSQ_DATA_W-1:0] cdbData_i,
  output logic                  ready_o,
  output logic                  store_o,
  output logic [LSQ_DATA_W-1:0] addr_o,
  output logic [LSQ_DATA_W-1:0] wdata_o,
  output logic [LSQ_TAG_W-1:0]  rdTag_o
);

  lsq_entry_t entry_q, entry_d;

  // Next slot contents: new writes take a same-cycle CDB bypass, occupied
  // slots snoop the CDB, a pop frees the slot, and clear wins over everything.
  always_comb begin
    entry_d = entry_q;
    if (write_i) begin
      entry_d = wrEntry_i;
      if (cdbHit(wrEntry_i.rsValid, wrEntry_i.rsTag, cdbValid_i, cdbTag_i)) begin
        entry_d.rsValid = 1'b1;
        entry_d.rsData  = cdbData_i;
      end
      if (cdbHit(wrEntry_i.rtValid, wrEntry_i.rtTag, cdbValid_i, cdbTag_i)) begin
        entry_d.rtValid = 1'b1;
        entry_d.rtData  = cdbData_i;
      end
    end else if (entry_q.valid) begin
      if (pop_i) begin
        entry_d.valid = 1'b0;
      end else begin
        if (cdbHit(entry_q.rsValid, entry_q.rsTag, cdbValid_i, cdbTag_i)) begin
          entry_d.rsValid = 1'b1;
          entry_d.rsData  = cdbData_i;
        end
        if (cdbHit(entry_q.rtValid, entry_q.rtTag, cdbValid_i, cdbTag_i)) begin
          entry_d.rtValid = 1'b1;
          entry_d.rtData  = cdbData_i;
        end
      end
    end
    if (clear_i) begin
      entry_d.valid = 1'b0;
    end
  end

  // Slot register; reset wipes the whole record so outputs read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  // Issue view of the slot: loads only need the base, stores need both.
  always_comb begin
    ready_o = entry_q.valid && entry_q.rsValid && (!entry_q.store || entry_q.rtValid);
    store_o = entry_q.store;
    addr_o  = entry_q.rsData + LSQ_DATA_W'($signed(entry_q.imm));
    wdata_o = entry_q.rtData;
    rdTag_o = entry_q.rdTag;
  end

endmodule

// File: rtl/lsqueue.sv
// In-order load/store queue: circular FIFO of lsq_entry slots, issuing the
// head op to memory once its operands are available.
module lsqueue
  import lsqueue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = LSQ_TAG_W,
  parameter int DATA_W = LSQ_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dispatch_en,
  input  logic                     dispatch_store,
  input  logic [15:0]              dispatch_imm,
  input  logic [DATA_W-1:0]        dispatch_rsdata,
  input  logic [DATA_W-1:0]        dispatch_rtdata,
  input  logic [TAG_W-1:0]         dispatch_rstag,
  input  logic [TAG_W-1:0]         dispatch_rttag,
  input  logic                     dispatch_rsvalid,
  input  logic                     dispatch_rtvalid,
  input  logic [TAG_W-1:0]         dispatch_rdtag,
  output logic                     dispatch_ready,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [DATA_W-1:0]        cdb_data,
  input  logic                     flush,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic                     issue_store,
  output logic [DATA_W-1:0]        issue_addr,
  output logic [DATA_W-1:0]        issue_wdata,
  output logic [TAG_W-1:0]         issue_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic enq, deq;
  lsq_entry_t newEntry;

  logic [DEPTH-1:0]      slotReady;
  logic [DEPTH-1:0]      slotStore;
  logic [LSQ_DATA_W-1:0] slotAddr  [DEPTH];
  logic [LSQ_DATA_W-1:0] slotWdata [DEPTH];
  logic [LSQ_TAG_W-1:0]  slotTag   [DEPTH];

  // Handshakes: a full queue refuses dispatch even when the head leaves.
  always_comb begin
    dispatch_ready = (count_q != CNT_W'(DEPTH));
    enq            = dispatch_en && dispatch_ready;
    deq            = issue_valid && issue_ready;
  end

  // Package the incoming op; bypass against the CDB happens in the slot.
  always_comb begin
    newEntry         = '0;
    newEntry.valid   = 1'b1;
    newEntry.store   = dispatch_store;
    newEntry.imm     = dispatch_imm;
    newEntry.rsData  = LSQ_DATA_W'(dispatch_rsdata);
    newEntry.rtData  = LSQ_DATA_W'(dispatch_rtdata);
    newEntry.rsTag   = LSQ_TAG_W'(dispatch_rstag);
    newEntry.rtTag   = LSQ_TAG_W'(dispatch_rttag);
    newEntry.rsValid = dispatch_rsvalid;
    newEntry.rtValid = dispatch_rtvalid;
    newEntry.rdTag   = LSQ_TAG_W'(dispatch_rdtag);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gSlot
    lsq_entry uEntry (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (flush),
      .write_i    (enq && (tail_q == PTR_W'(i))),
      .wrEntry_i  (newEntry),
      .pop_i      (deq && (head_q == PTR_W'(i))),
      .cdbValid_i (cdb_valid),
      .cdbTag_i   (LSQ_TAG_W'(cdb_tag)),
      .cdbData_i  (LSQ_DATA_W'(cdb_data)),
      .ready_o    (slotReady[i]),
      .store_o    (slotStore[i]),
      .addr_o     (slotAddr[i]),
      .wdata_o    (slotWdata[i]),
      .rdTag_o    (slotTag[i])
    );
  end

  // Head slot drives the issue port; fields read zero while nothing is ready.
  always_comb begin
    issue_valid = slotReady[head_q];
    issue_store = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;
    issue_tag   = '0;
    if (issue_valid) begin
      issue_store = slotStore[head_q];
      issue_addr  = DATA_W'(slotAddr[head_q]);
      issue_wdata = DATA_W'(slotWdata[head_q]);
      issue_tag   = TAG_W'(slotTag[head_q]);
    end
  end

  // Pointer and occupancy update; flush empties the queue outright.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      if (enq && !deq)      count_d = count_q + CNT_W'(1);
      else if (!enq && deq) count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO control registers; reset dominates flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
